// File: rtl/serial_divider.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock.
// Results are presented as {R, Q}, matching the serial multiplier's product packing.
module serial_divider #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     R,
  output logic [2*WIDTH-1:0]   RQ,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH:0]   w_t;

  // One extra bit so a divisor with its MSB set cannot wrap the trial subtraction.
  assign w_t = {r_r, r_q[WIDTH-1]} - {1'b0, r_m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_q     <= '0;
      r_r     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (load) begin
            r_m   <= B;
            r_cnt <= '0;
            if (B == '0) begin
              r_q     <= '1;
              r_r     <= A;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StDone;
            end else begin
              r_q     <= A;
              r_r     <= '0;
              r_dbz   <= 1'b0;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          if (!w_t[WIDTH]) begin
            r_r <= w_t[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= {r_r[WIDTH-2:0], r_q[WIDTH-1]};
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
          if (r_cnt == LastCnt) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign RQ          = {r_r, r_q};
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: stimulus pushes expected {dbz, R, Q},
// a negedge monitor pops and compares whenever a fresh result is presented.
module tb_serial_divider;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic [2*W-1:0] RQ;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  int total = 0;
  int bad = 0;

  logic [2*W:0] sb[$];
  logic         prev_done = 1'b0;
  logic         load_seen = 1'b0;

  serial_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .RQ          (RQ),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    return {1'b0, W'(a % b), W'(a / b)};
  endfunction

  always @(posedge clk) load_seen <= load;

  // Monitor: a result is fresh when done rises, or when a load re-enters DONE directly.
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (!rst) begin
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done && (!prev_done || load_seen)) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("Q", {28'd0, Q}, {28'd0, e[W-1:0]});
          check("R", {28'd0, R}, {28'd0, e[2*W-1:W]});
          check("RQ", {24'd0, RQ}, {24'd0, e[2*W-1:0]});
          check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[2*W]});
        end
      end
    end
    prev_done <= done;
  end

  // Issue one load; check latency (edges from load edge to done) and busy cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W:0] exp, input bit timing);
    int lat;
    int bc;
    sb.push_back(exp);
    @(negedge clk);
    A = a;
    B = b;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    lat = 1;
    bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (timing) begin
      check("latency", lat, (b == 0) ? 1 : W + 1);
      check("busy_cycles", bc, (b == 0) ? 0 : W);
    end else if (lat >= 20) begin
      check("done_timeout", 32'd1, 32'd0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    #2;
    check("rst_Q", {28'd0, Q}, 32'd0);
    check("rst_R", {28'd0, R}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed directed vectors: {dbz, R, Q}
    run_op(4'd13, 4'd3, {1'b0, 4'd1, 4'd4}, 1'b1);
    run_op(4'd15, 4'd8, {1'b0, 4'd7, 4'd1}, 1'b1);
    run_op(4'd7,  4'd9, {1'b0, 4'd7, 4'd0}, 1'b1);
    run_op(4'd9,  4'd0, {1'b1, 4'd9, 4'hF}, 1'b1);
    run_op(4'd9,  4'd0, {1'b1, 4'd9, 4'hF}, 1'b1);

    // Load pulsed mid-run with new operands must be ignored.
    sb.push_back({1'b0, 4'd0, 4'hF});
    @(negedge clk);
    A = 4'd15;
    B = 4'd1;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    A = 4'd2;
    B = 4'd2;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignored_load_latency", lat, W + 1);

    // Asynchronous reset mid-run.
    @(negedge clk);
    A = 4'd14;
    B = 4'd5;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_Q", {28'd0, Q}, 32'd0);
    check("arst_R", {28'd0, R}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    run_op(4'd14, 4'd5, {1'b0, 4'd4, 4'd2}, 1'b1);

    // Full operand sweep against the arithmetic model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), model(W'(a), W'(b)), 1'b0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
